// File: rtl/holo_pkg.sv
// Shared constants and types for the holographic display controller blocks.
package holo_pkg;

    localparam int NUM_TEXTURES = 8;
    localparam int TEX_WORDS    = 256;
    localparam int IDX_W        = 4;

    // MMIO addresses decoded by the CPU bus front end
    localparam int ADDR_BTN = 1000;
    localparam int ADDR_TEX = 1001;

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

endpackage

// File: rtl/swap_timer.sv
// Watchdog for a pending texture swap: pulses expire after TIMEOUT running cycles.
module swap_timer #(
    parameter int TIMEOUT = 5000000,
    parameter int TMR_W   = 23
) (
    input  logic clk,
    input  logic resetn,
    input  logic run,
    input  logic clear,
    output logic expire
);

    logic [TMR_W-1:0] count_reg;

    localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

    assign expire = run && (count_reg == LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_reg <= '0;
        end else if (clear || !run || expire) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + TMR_W'(1);
        end
    end

endmodule

// File: rtl/texture_swap_ctrl.sv
// Holds a CPU-written texture index until a revolution boundary (or timeout)
// and generates the texture ROM word address for the active texture.
module texture_swap_ctrl
    import holo_pkg::IDX_W, holo_pkg::state_t, holo_pkg::IDLE, holo_pkg::PENDING;
#(
    parameter int NUM_TEXTURES = holo_pkg::NUM_TEXTURES,
    parameter int TEX_WORDS    = holo_pkg::TEX_WORDS,
    parameter int ADDR_W       = 11,
    parameter int TIMEOUT      = 5000000,
    parameter int TMR_W        = 23
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              idx_wr,
    input  logic [IDX_W-1:0]  idx_data,
    input  logic              frame_start,
    input  logic              pix_adv,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [IDX_W-1:0]  active_idx,
    output logic              pending,
    output logic              swap_done,
    output logic              swap_forced,
    output logic              idx_err
);

    localparam int OFF_W = $clog2(TEX_WORDS);
    localparam logic [IDX_W:0] NUM_T = (IDX_W + 1)'(NUM_TEXTURES);

    state_t             state_reg;
    logic [IDX_W-1:0]   pend_idx_reg;
    logic [OFF_W-1:0]   offset_reg;
    logic               legal_wr;
    logic               expire;
    logic               swap;

    assign legal_wr = idx_wr && ({1'b0, idx_data} < NUM_T);
    // A swap always takes the index that was pending before this cycle's write
    assign swap     = (state_reg == PENDING) && (frame_start || expire);
    assign pending  = (state_reg == PENDING);
    assign rom_addr = (ADDR_W'(active_idx) << OFF_W) | ADDR_W'(offset_reg);

    swap_timer #(
        .TIMEOUT (TIMEOUT),
        .TMR_W   (TMR_W)
    ) u_swap_timer (
        .clk    (clk),
        .resetn (resetn),
        .run    (state_reg == PENDING),
        .clear  (legal_wr || swap),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            pend_idx_reg <= '0;
            active_idx   <= '0;
            offset_reg   <= '0;
            swap_done    <= 1'b0;
            swap_forced  <= 1'b0;
            idx_err      <= 1'b0;
        end else begin
            swap_done   <= swap;
            swap_forced <= swap && !frame_start;

            if (swap) begin
                active_idx <= pend_idx_reg;
            end

            if (frame_start || swap) begin
                offset_reg <= '0;
            end else if (pix_adv) begin
                offset_reg <= offset_reg + OFF_W'(1);
            end

            // A legal write re-arms PENDING even on the cycle a swap retires it
            if (legal_wr) begin
                pend_idx_reg <= idx_data;
                idx_err      <= 1'b0;
                state_reg    <= PENDING;
            end else begin
                if (idx_wr) begin
                    idx_err <= 1'b1;
                end
                if (swap) begin
                    state_reg <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_texture_swap_ctrl.sv
// Scoreboard bench for texture_swap_ctrl with a short timeout.
module tb_texture_swap_ctrl;

    localparam int ADDR_W  = 11;
    localparam int TIMEOUT = 16;
    localparam int TMR_W   = 5;

    logic              clk;
    logic              resetn;
    logic              idx_wr;
    logic [3:0]        idx_data;
    logic              frame_start;
    logic              pix_adv;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        active_idx;
    logic              pending;
    logic              swap_done;
    logic              swap_forced;
    logic              idx_err;

    typedef struct {
        logic [3:0] idx;
        logic       forced;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_fails;

    texture_swap_ctrl #(
        .NUM_TEXTURES (8),
        .TEX_WORDS    (256),
        .ADDR_W       (ADDR_W),
        .TIMEOUT      (TIMEOUT),
        .TMR_W        (TMR_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .idx_wr      (idx_wr),
        .idx_data    (idx_data),
        .frame_start (frame_start),
        .pix_adv     (pix_adv),
        .rom_addr    (rom_addr),
        .active_idx  (active_idx),
        .pending     (pending),
        .swap_done   (swap_done),
        .swap_forced (swap_forced),
        .idx_err     (idx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_wr(input logic [3:0] d);
        idx_wr   = 1'b1;
        idx_data = d;
        cyc();
        idx_wr   = 1'b0;
    endtask

    task automatic expect_swap(input logic [3:0] idx, input logic forced);
        exp_t e;
        e.idx    = idx;
        e.forced = forced;
        sb.push_back(e);
    endtask

    // Every swap_done pulse must match the oldest outstanding expected swap
    always @(negedge clk) begin
        if (resetn && swap_done) begin
            if (sb.size() == 0) begin
                check("unexpected_swap", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("swap_idx", int'(active_idx), int'(e.idx));
                check("swap_forced", int'(swap_forced), int'(e.forced));
            end
        end
    end

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        resetn      = 1'b0;
        idx_wr      = 1'b0;
        idx_data    = '0;
        frame_start = 1'b0;
        pix_adv     = 1'b0;

        cyc();
        cyc();
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_active", int'(active_idx), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_swap_done", int'(swap_done), 0);
        check("rst_forced", int'(swap_forced), 0);
        check("rst_idx_err", int'(idx_err), 0);
        resetn = 1'b1;
        cyc();

        // Column advance with no texture change
        pix_adv = 1'b1;
        repeat (5) cyc();
        pix_adv = 1'b0;
        check("adv5_rom_addr", int'(rom_addr), 5);
        check("adv5_active", int'(active_idx), 0);
        check("adv5_pending", int'(pending), 0);
        check("adv5_idx_err", int'(idx_err), 0);

        // Legal write waits for the revolution boundary
        pulse_wr(4'd3);
        for (int i = 0; i < 3; i++) begin
            check("wr3_pending", int'(pending), 1);
            check("wr3_active_hold", int'(active_idx), 0);
            cyc();
        end
        check("wr3_pending", int'(pending), 1);
        frame_start = 1'b1;
        expect_swap(4'd3, 1'b0);
        cyc();
        frame_start = 1'b0;
        check("fs_active", int'(active_idx), 3);
        check("fs_rom_addr", int'(rom_addr), 768);
        check("fs_swap_done", int'(swap_done), 1);
        check("fs_pending", int'(pending), 0);
        cyc();
        check("fs_swap_done_1cyc", int'(swap_done), 0);

        // Out-of-range write only flags an error
        pulse_wr(4'd9);
        check("bad_idx_err", int'(idx_err), 1);
        check("bad_pending", int'(pending), 0);
        check("bad_active", int'(active_idx), 3);
        pulse_wr(4'd2);
        check("good_idx_err", int'(idx_err), 0);
        check("good_pending", int'(pending), 1);
        frame_start = 1'b1;
        expect_swap(4'd2, 1'b0);
        cyc();
        frame_start = 1'b0;
        check("wr2_active", int'(active_idx), 2);

        // Forced swap on the TIMEOUT-th cycle after the write
        pulse_wr(4'd5);
        expect_swap(4'd5, 1'b1);
        pix_adv = 1'b1;
        for (int i = 1; i < TIMEOUT; i++) begin
            cyc();
            check("to_wait_pending", int'(pending), 1);
            check("to_wait_no_swap", int'(swap_done), 0);
        end
        cyc();
        pix_adv = 1'b0;
        check("to_active", int'(active_idx), 5);
        check("to_swap_done", int'(swap_done), 1);
        check("to_swap_forced", int'(swap_forced), 1);
        check("to_rom_addr", int'(rom_addr), 5 * 256);
        check("to_pending", int'(pending), 0);

        // Write coinciding with the boundary: old index swaps, new one pends
        pulse_wr(4'd1);
        cyc();
        idx_wr      = 1'b1;
        idx_data    = 4'd6;
        frame_start = 1'b1;
        expect_swap(4'd1, 1'b0);
        cyc();
        idx_wr      = 1'b0;
        frame_start = 1'b0;
        check("coinc_active", int'(active_idx), 1);
        check("coinc_pending", int'(pending), 1);
        cyc();
        frame_start = 1'b1;
        expect_swap(4'd6, 1'b0);
        cyc();
        frame_start = 1'b0;
        check("coinc2_active", int'(active_idx), 6);
        check("coinc2_pending", int'(pending), 0);

        // Offset wraps within the texture
        pix_adv = 1'b1;
        repeat (255) cyc();
        check("wrap_last", int'(rom_addr), 6 * 256 + 255);
        cyc();
        pix_adv = 1'b0;
        check("wrap_base", int'(rom_addr), 6 * 256);
        check("wrap_active", int'(active_idx), 6);

        // Reset mid-PENDING discards the pending index
        pulse_wr(4'd4);
        cyc();
        resetn = 1'b0;
        #1;
        check("mid_rst_rom_addr", int'(rom_addr), 0);
        check("mid_rst_active", int'(active_idx), 0);
        check("mid_rst_pending", int'(pending), 0);
        check("mid_rst_swap_done", int'(swap_done), 0);
        cyc();
        resetn = 1'b1;
        repeat (TIMEOUT + 8) cyc();
        check("post_rst_active", int'(active_idx), 0);
        check("post_rst_pending", int'(pending), 0);

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
        $finish;
    end

endmodule
